byte_tx_scheduler: RTL and testbench

BYTE_TX_SCHEDULER -- requirements
Module: byte_tx_scheduler

---
 rtl/byte_tx_scheduler.sv | 171 +++++++++++++++++
 tb/tb_byte_tx_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/byte_tx_scheduler.sv
// byte_tx_scheduler
// Two-requester word-to-byte serializer. A round-robin arbiter picks one
// requester while idle, latches its 32-bit word and byte count, then emits
// the word one byte per accepted cycle on a valid/ready byte stream.
// Byte order inside the word is chosen by LSB_FIRST.

module byte_tx_scheduler #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [1:0]  req0_len,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [1:0]  req1_len,
    output logic        req1_ready,

    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        out_src,
    input  logic        out_ready,

    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] data_r;
    logic [1:0]  len_r;
    logic [1:0]  idx_r;
    logic        src_r;
    logic        ptr_r;

    logic        grant_s;
    logic        winner_s;
    logic        last_s;
    logic        advance_s;

    // Byte lane selection: idx counts bytes in transmit order, so the lane
    // walks up from bits [7:0] when LSB_FIRST is set and down from [31:24]
    // otherwise.
    function automatic logic [7:0] select_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input bit          lsb_first
    );
        logic [7:0] sel;
        sel = 8'h00;
        if (lsb_first) begin
            case (idx)
                2'd0:    sel = word[7:0];
                2'd1:    sel = word[15:8];
                2'd2:    sel = word[23:16];
                2'd3:    sel = word[31:24];
                default: sel = 8'h00;
            endcase
        end else begin
            case (idx)
                2'd0:    sel = word[31:24];
                2'd1:    sel = word[23:16];
                2'd2:    sel = word[15:8];
                2'd3:    sel = word[7:0];
                default: sel = 8'h00;
            endcase
        end
        return sel;
    endfunction

    assign last_s    = (idx_r == len_r);
    assign advance_s = (state_r == SEND) && out_ready;

    // Arbitration: only while idle (and out of reset); a lone requester wins
    // outright, contention is resolved by the round-robin pointer.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = ptr_r;
        if ((state_r == IDLE) && !reset) begin
            if (req0_valid && req1_valid) begin
                grant_s  = 1'b1;
                winner_s = ptr_r;
            end else if (req0_valid) begin
                grant_s  = 1'b1;
                winner_s = 1'b0;
            end else if (req1_valid) begin
                grant_s  = 1'b1;
                winner_s = 1'b1;
            end else begin
                grant_s  = 1'b0;
                winner_s = ptr_r;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = ptr_r;
        end
    end

    // Next-state logic: a grant starts a word, the accepted last byte ends it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (advance_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word capture, byte index and round-robin pointer. idx is left at its
    // final value on return to IDLE so out_byte keeps showing the last byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= 32'h0000_0000;
            len_r  <= 2'd0;
            idx_r  <= 2'd0;
            src_r  <= 1'b0;
            ptr_r  <= 1'b0;
        end else if (grant_s) begin
            data_r <= winner_s ? req1_data : req0_data;
            len_r  <= winner_s ? req1_len  : req0_len;
            idx_r  <= 2'd0;
            src_r  <= winner_s;
            ptr_r  <= ~winner_s;
        end else if (advance_s && !last_s) begin
            idx_r  <= idx_r + 2'd1;
        end else begin
            idx_r  <= idx_r;
        end
    end

    assign req0_ready = grant_s && (winner_s == 1'b0);
    assign req1_ready = grant_s && (winner_s == 1'b1);

    assign out_valid  = (state_r == SEND);
    assign busy       = (state_r == SEND);
    assign out_last   = (state_r == SEND) && last_s;
    assign out_src    = src_r;
    assign out_byte   = select_byte(data_r, idx_r, LSB_FIRST);

endmodule

// File: tb/tb_byte_tx_scheduler.sv
// Directed bench for byte_tx_scheduler. Two instances share every input:
// dut_a uses LSB_FIRST=1, dut_b uses LSB_FIRST=0, so each byte check covers
// both orderings. Inputs change on the falling edge, outputs are sampled 1
// time unit later, well away from the rising edge.

module tb_byte_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic [1:0]  req0_len, req1_len;
    logic        out_ready;

    logic        req0_ready_a, req1_ready_a, out_valid_a, out_last_a, out_src_a, busy_a;
    logic [7:0]  out_byte_a;
    logic        req0_ready_b, req1_ready_b, out_valid_b, out_last_b, out_src_b, busy_b;
    logic [7:0]  out_byte_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    byte_tx_scheduler #(.LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_len(req0_len), .req0_ready(req0_ready_a),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_len(req1_len), .req1_ready(req1_ready_a),
        .out_valid(out_valid_a), .out_byte(out_byte_a), .out_last(out_last_a), .out_src(out_src_a),
        .out_ready(out_ready), .busy(busy_a)
    );

    byte_tx_scheduler #(.LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_len(req0_len), .req0_ready(req0_ready_b),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_len(req1_len), .req1_ready(req1_ready_b),
        .out_valid(out_valid_b), .out_byte(out_byte_b), .out_last(out_last_b), .out_src(out_src_b),
        .out_ready(out_ready), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output stream of both instances against hand-computed values.
    task automatic check_out(input string tag, input logic valid, input logic [7:0] byte_a,
                             input logic [7:0] byte_b, input logic last, input logic src);
        check_eq({tag, ".valid_a"}, {31'd0, out_valid_a}, {31'd0, valid});
        check_eq({tag, ".valid_b"}, {31'd0, out_valid_b}, {31'd0, valid});
        check_eq({tag, ".busy_a"},  {31'd0, busy_a},      {31'd0, valid});
        check_eq({tag, ".byte_a"},  {24'd0, out_byte_a},  {24'd0, byte_a});
        check_eq({tag, ".byte_b"},  {24'd0, out_byte_b},  {24'd0, byte_b});
        check_eq({tag, ".last_a"},  {31'd0, out_last_a},  {31'd0, last});
        check_eq({tag, ".last_b"},  {31'd0, out_last_b},  {31'd0, last});
        check_eq({tag, ".src_a"},   {31'd0, out_src_a},   {31'd0, src});
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        check_eq({tag, ".rdy0_a"}, {31'd0, req0_ready_a}, {31'd0, r0});
        check_eq({tag, ".rdy1_a"}, {31'd0, req1_ready_a}, {31'd0, r1});
        check_eq({tag, ".rdy0_b"}, {31'd0, req0_ready_b}, {31'd0, r0});
        check_eq({tag, ".rdy1_b"}, {31'd0, req1_ready_b}, {31'd0, r1});
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'h0000_0000;
        req1_data  = 32'h0000_0000;
        req0_len   = 2'd0;
        req1_len   = 2'd0;
        out_ready  = 1'b1;

        // Reset state: requests pending but nothing granted.
        repeat (2) @(negedge clk);
        #1;
        check_ready("rst", 1'b0, 1'b0);
        check_out("rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Single requester, 4-byte word.
        @(negedge clk);
        reset      = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 32'hDDCC_BBAA;
        req0_len   = 2'd3;
        #1;
        check_ready("s1.grant", 1'b1, 1'b0);
        @(negedge clk); req0_valid = 1'b0; #1;
        check_ready("s1.send", 1'b0, 1'b0);
        check_out("s1.b0", 1'b1, 8'hAA, 8'hDD, 1'b0, 1'b0);
        @(negedge clk); #1; check_out("s1.b1", 1'b1, 8'hBB, 8'hCC, 1'b0, 1'b0);
        @(negedge clk); #1; check_out("s1.b2", 1'b1, 8'hCC, 8'hBB, 1'b0, 1'b0);
        @(negedge clk); #1; check_out("s1.b3", 1'b1, 8'hDD, 8'hAA, 1'b1, 1'b0);
        @(negedge clk); #1; check_out("s1.idle", 1'b0, 8'hDD, 8'hAA, 1'b0, 1'b0);

        // Contention from reset: req0, req1, req0, req1 ...
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'hC000_00A0;
        req1_data  = 32'hD100_00B1;
        req0_len   = 2'd0;
        req1_len   = 2'd0;
        #1;
        check_ready("s2.g0", 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check_out("s2.w0", 1'b1, 8'hA0, 8'hC0, 1'b1, 1'b0);
            check_ready("s2.send0", 1'b0, 1'b0);
            @(negedge clk); #1;
            check_out("s2.bubble0", 1'b0, 8'hA0, 8'hC0, 1'b0, 1'b0);
            check_ready("s2.g1", 1'b0, 1'b1);
            @(negedge clk); #1;
            check_out("s2.w1", 1'b1, 8'hB1, 8'hD1, 1'b1, 1'b1);
            @(negedge clk); #1;
            check_ready("s2.g0", 1'b1, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check_ready("s2.none", 1'b0, 1'b0);
        @(negedge clk); #1;
        check_out("s2.idle", 1'b0, 8'hB1, 8'hD1, 1'b0, 1'b1);

        // Backpressure on byte 0 of a 2-byte word from req1.
        req1_valid = 1'b1;
        req1_data  = 32'h1234_5678;
        req1_len   = 2'd1;
        #1;
        check_ready("s3.grant", 1'b0, 1'b1);
        @(negedge clk); req1_valid = 1'b0; out_ready = 1'b0; #1;
        check_out("s3.hold0", 1'b1, 8'h78, 8'h12, 1'b0, 1'b1);
        @(negedge clk); #1; check_out("s3.hold1", 1'b1, 8'h78, 8'h12, 1'b0, 1'b1);
        @(negedge clk); #1; check_out("s3.hold2", 1'b1, 8'h78, 8'h12, 1'b0, 1'b1);
        @(negedge clk); out_ready = 1'b1; #1;
        check_out("s3.hold3", 1'b1, 8'h78, 8'h12, 1'b0, 1'b1);
        @(negedge clk); #1; check_out("s3.b1", 1'b1, 8'h56, 8'h34, 1'b1, 1'b1);
        @(negedge clk); #1; check_out("s3.idle", 1'b0, 8'h56, 8'h34, 1'b0, 1'b1);

        // Single-byte word: ordering decides which lane is sent.
        req0_valid = 1'b1;
        req0_data  = 32'hA1B2_C3D4;
        req0_len   = 2'd0;
        #1;
        check_ready("s4.grant", 1'b1, 1'b0);
        @(negedge clk); req0_valid = 1'b0; #1;
        check_out("s4.b0", 1'b1, 8'hD4, 8'hA1, 1'b1, 1'b0);
        @(negedge clk); #1; check_out("s4.idle", 1'b0, 8'hD4, 8'hA1, 1'b0, 1'b0);

        // Reset in the middle of a 4-byte word.
        req0_valid = 1'b1;
        req0_data  = 32'h1122_3344;
        req0_len   = 2'd3;
        #1;
        check_ready("s5.grant", 1'b1, 1'b0);
        @(negedge clk); req0_valid = 1'b0; #1;
        check_out("s5.b0", 1'b1, 8'h44, 8'h11, 1'b0, 1'b0);
        @(negedge clk); #1; check_out("s5.b1", 1'b1, 8'h33, 8'h22, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        check_out("s5.rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check_ready("s5.rst", 1'b0, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'h5566_7788;
        req0_len   = 2'd1;
        req1_data  = 32'hEEEE_EEEE;
        req1_len   = 2'd0;
        #1;
        check_ready("s5.regrant", 1'b1, 1'b0);
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; #1;
        check_out("s5.nb0", 1'b1, 8'h88, 8'h55, 1'b0, 1'b0);
        @(negedge clk); #1; check_out("s5.nb1", 1'b1, 8'h77, 8'h66, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
